// File: rtl/cpu_core.sv
// cpu_core: 16-bit single-cycle load/store CPU with internal ROM, 4x16 register file, ALU and data RAM.
// Build option: define CPU_ZERO_REG_EN to hard-wire r0 to zero.
module cpu_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pcFill,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AluOp,
  output logic [1:0]  opcode
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {
    OP_R    = 2'b00,
    OP_LW   = 2'b01,
    OP_SW   = 2'b10,
    OP_ADDI = 2'b11
  } opcode_e;

  logic [15:0]    pc_q;
  logic [15:0]    pc_d;
  logic [15:0]    regs [0:3];
  logic [15:0]    dmem [0:DMEM_WORDS-1];

  logic [IAW-1:0] imemIdx;
  logic [15:0]    instr;
  opcode_e        op;
  logic [1:0]     rs;
  logic [1:0]     rt;
  logic [1:0]     rd;
  logic [1:0]     wrReg;
  logic [2:0]     funct;
  logic [15:0]    immExt;
  logic [15:0]    rsVal;
  logic [15:0]    rtVal;
  logic [15:0]    opB;
  logic [15:0]    aluResult;
  logic [DAW-1:0] dmemIdx;
  logic [15:0]    memRdata;
  logic [15:0]    wbData;
  logic           wrAllowed;

  // The byte-addressed PC aliases onto the ROM depth; bit 0 never selects a word.
  assign imemIdx = pc_q[IAW:1];
  assign pcFill  = pc_q;
  assign pc_d    = pc_q + 16'd2;

  always_comb begin
    instr = 16'h0000;
    case (imemIdx)
      IAW'(0): instr = 16'hC405;
      IAW'(1): instr = 16'hC803;
      IAW'(2): instr = 16'h1B00;
      IAW'(3): instr = 16'h8C04;
      IAW'(4): instr = 16'h4404;
      IAW'(5): instr = 16'h3601;
      default: instr = 16'h0000;
    endcase
  end

  assign op     = opcode_e'(instr[15:14]);
  assign opcode = instr[15:14];
  assign rs     = instr[13:12];
  assign rt     = instr[11:10];
  assign rd     = instr[9:8];
  assign funct  = instr[2:0];
  assign immExt = {{6{instr[9]}}, instr[9:0]};

  always_comb begin
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AluOp    = 1'b0;
    case (op)
      OP_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        AluOp    = 1'b1;
      end
      OP_LW: begin
        AluSrc   = 1'b1;
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        MemRead  = 1'b1;
      end
      OP_SW: begin
        AluSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_ADDI: begin
        AluSrc   = 1'b1;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CPU_ZERO_REG_EN
  assign rsVal     = (rs == 2'd0) ? 16'h0000 : regs[rs];
  assign rtVal     = (rt == 2'd0) ? 16'h0000 : regs[rt];
  assign wrAllowed = (wrReg != 2'd0);
`else
  assign rsVal     = regs[rs];
  assign rtVal     = regs[rt];
  assign wrAllowed = 1'b1;
`endif

  assign opB = AluSrc ? immExt : rtVal;

  always_comb begin
    aluResult = rsVal + opB;
    if (AluOp) begin
      case (funct)
        3'b000:  aluResult = rsVal + opB;
        3'b001:  aluResult = rsVal - opB;
        3'b010:  aluResult = rsVal & opB;
        3'b011:  aluResult = rsVal | opB;
        3'b100:  aluResult = ($signed(rsVal) < $signed(opB)) ? 16'd1 : 16'd0;
        3'b101:  aluResult = rsVal ^ opB;
        3'b110:  aluResult = rsVal << opB[3:0];
        default: aluResult = rsVal >> opB[3:0];
      endcase
    end
  end

  // Data address drops its low bit and aliases onto the RAM depth.
  assign dmemIdx  = aluResult[DAW:1];
  assign memRdata = dmem[dmemIdx];
  assign wbData   = MemToReg ? memRdata : aluResult;
  assign wrReg    = RegDst ? rd : rt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 16'h0000;
      end
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= 16'h0000;
      end
    end else begin
      pc_q <= pc_d;
      if (RegWrite && wrAllowed) begin
        regs[wrReg] <= wbData;
      end
      if (MemWrite) begin
        dmem[dmemIdx] <= rtVal;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: scoreboard bench for cpu_core; an ISA-level reference model predicts PC, decode, registers and RAM.
module tb_cpu_core;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic [15:0] pcFill;
  logic        RegDst;
  logic        AluSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        AluOp;
  logic [1:0]  opcode;

  cpu_core dut (
    .clk      (clk),
    .reset    (reset),
    .pcFill   (pcFill),
    .RegDst   (RegDst),
    .AluSrc   (AluSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .AluOp    (AluOp),
    .opcode   (opcode)
  );

  // Clock starts high so the first falling edge precedes the first rising edge.
  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]       pc;
    logic [8:0]        ctrl;
    logic [3:0][15:0]  regs;
    logic [63:0][15:0] mem;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  logic [15:0] mPc;
  logic [15:0] mReg [4];
  logic [15:0] mMem [64];
  logic [15:0] prog [0:5] = '{16'hC405, 16'hC803, 16'h1B00, 16'h8C04, 16'h4404, 16'h3601};

  // Control word order: RegDst AluSrc MemToReg RegWrite MemRead MemWrite AluOp opcode[1:0].
  localparam logic [8:0] CTRL_ADDI = 9'b0101000_11;

  function automatic logic [15:0] fetch(input logic [15:0] pc);
    int w;
    w = (int'(pc) / 2) % 64;
    return (w < 6) ? prog[w] : 16'h0000;
  endfunction

  function automatic logic [8:0] expCtrl(input logic [15:0] ins);
    case (ins[15:14])
      2'b00:   return 9'b1001001_00;
      2'b01:   return 9'b0111100_01;
      2'b10:   return 9'b0100010_10;
      default: return 9'b0101000_11;
    endcase
  endfunction

  task automatic writeReg(input int r, input logic [15:0] v);
`ifdef CPU_ZERO_REG_EN
    if (r != 0) mReg[r] = v;
`else
    mReg[r] = v;
`endif
  endtask

  task automatic modelReset();
    mPc = 16'h0000;
    for (int i = 0; i < 4; i++) mReg[i] = 16'h0000;
    for (int i = 0; i < 64; i++) mMem[i] = 16'h0000;
  endtask

  // Executes one instruction from the ISA definition.
  task automatic modelStep();
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int op;
    int rs;
    int rt;
    int rd;
    int fn;
    int imm;
    int idx;
    ins = fetch(mPc);
    op  = int'(ins[15:14]);
    rs  = int'(ins[13:12]);
    rt  = int'(ins[11:10]);
    rd  = int'(ins[9:8]);
    fn  = int'(ins[2:0]);
    imm = int'(ins[9:0]);
    if (imm >= 512) imm = imm - 1024;
    a   = mReg[rs];
    b   = mReg[rt];
    idx = (((int'(a) + imm) & 32'hFFFF) / 2) % 64;
    case (op)
      0: begin
        case (fn)
          0: res = a + b;
          1: res = a - b;
          2: res = a & b;
          3: res = a | b;
          4: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          5: res = a ^ b;
          6: res = a << b[3:0];
          default: res = a >> b[3:0];
        endcase
        writeReg(rd, res);
      end
      1: writeReg(rt, mMem[idx]);
      2: mMem[idx] = b;
      default: writeReg(rt, 16'(int'(a) + imm));
    endcase
    mPc = mPc + 16'd2;
  endtask

  function automatic expT snap();
    expT e;
    e.pc   = mPc;
    e.ctrl = expCtrl(fetch(mPc));
    for (int i = 0; i < 4; i++) e.regs[i] = mReg[i];
    for (int i = 0; i < 64; i++) e.mem[i] = mMem[i];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model follows every rising clock and reset; a reset drops any expectation it aborted.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelReset();
      expQ.delete();
    end else begin
      modelStep();
    end
    expQ.push_back(snap());
  end

  // Monitor: the architectural state is always presented, so compare on every falling edge.
  initial begin
    expT e;
    int  bad;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc", 64'(pcFill), 64'(e.pc));
        checkOutput("ctrl", 64'({RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp, opcode}), 64'(e.ctrl));
        checkOutput("regs", {dut.regs[3], dut.regs[2], dut.regs[1], dut.regs[0]}, 64'(e.regs));
        bad = -1;
        for (int i = 0; i < 64; i++) begin
          if (bad < 0 && dut.dmem[i] !== e.mem[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("[TB] FAIL dmem[%0d] actual=%h expected=%h", bad, dut.dmem[bad], e.mem[bad]);
        end
      end
    end
  end

  // Advance n rising edges and settle mid-way through the high phase.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("resetPc", 64'(pcFill), 64'h0);
    checkOutput("resetCtrl", 64'({RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp, opcode}), 64'(CTRL_ADDI));

    applyStimulus(2);
    checkOutput("addCtrl", 64'({RegDst, AluOp, AluSrc}), 64'b110);
    applyStimulus(1);
    checkOutput("regsAfter3", {dut.regs[3], dut.regs[2], dut.regs[1]}, 64'h0008_0003_0005);
    checkOutput("swCtrl", 64'({MemWrite, RegWrite}), 64'b10);
    applyStimulus(1);
    checkOutput("dmem2After4", 64'(dut.dmem[2]), 64'h8);
    checkOutput("lwCtrl", 64'({MemRead, MemToReg}), 64'b11);
    applyStimulus(2);
    checkOutput("pcAfter6", 64'(pcFill), 64'h000C);
    checkOutput("subResult", 64'(dut.regs[2]), 64'h0);

    pulseReset();
    applyStimulus(4);
    checkOutput("pcBeforeReset", 64'(pcFill), 64'h0008);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetPc", 64'(pcFill), 64'h0);
    checkOutput("asyncResetRegs", {dut.regs[3], dut.regs[2], dut.regs[1], dut.regs[0]}, 64'h0);
    checkOutput("asyncResetDmem2", 64'(dut.dmem[2]), 64'h0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Random run lengths, reset timing within the high phase and reset hold lengths.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(int'($urandom_range(1, 12)));
      #($urandom_range(0, 2));
      reset = 1'b1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      reset = 1'b0;
    end

    pulseReset();
    applyStimulus(32768);
    checkOutput("wrapPc", 64'(pcFill), 64'h0);
    checkOutput("wrapCtrl", 64'({RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp, opcode}), 64'(CTRL_ADDI));

    @(negedge clk);
    #1;
    checkOutput("queueDrained", 64'(expQ.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
